latch_shift_out: RTL and testbench

//  Read side of the 8-bit data latch: accepts a latched parallel word and shifts it out serially
//  to a downstream shift/storage register chain (74HC595-style LED / 7-seg drivers on the board).

---
 rtl/latch_pkg.sv | 13 +
 rtl/latch_shift_out_clk_div_tick.sv | 24 ++
 rtl/latch_shift_out.sv | 131 +++++++++++++
 tb/tb_latch_shift_out.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/latch_pkg.sv
// Shared definitions for the latch-side blocks: FSM state encodings and default geometry.
package latch_pkg;

   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_CLK_DIV = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

endpackage

// File: rtl/latch_shift_out_clk_div_tick.sv
// Divider that pulses tick in the terminal-count cycle; held cleared while en is low.
module clk_div_tick #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;

   assign tick = en && (div_cnt == TERM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             div_cnt <= '0;
      else if (!en || tick)   div_cnt <= '0;
      else                    div_cnt <= div_cnt + CW'(1);
   end

endmodule

// File: rtl/latch_shift_out.sv
// Serialises a latched parallel word onto a 74HC595-style chain (sclk/sdat/rclk).
// Define LSB_FIRST_EN to send din[0] first; default sends din[WIDTH-1] first.
module latch_shift_out
   import latch_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             sdat,
   output logic             rclk
);

   localparam int unsigned BW = $clog2(WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [BW-1:0]    bit_cnt, bit_cnt_n;
   logic             ready_n, busy_n, done_n, sclk_n, sdat_n, rclk_n;
   logic             tick;

   clk_div_tick #(.CLK_DIV(CLK_DIV)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state != IDLE),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         sclk    <= 1'b0;
         sdat    <= 1'b0;
         rclk    <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_cnt <= bit_cnt_n;
         ready   <= ready_n;
         busy    <= busy_n;
         done    <= done_n;
         sclk    <= sclk_n;
         sdat    <= sdat_n;
         rclk    <= rclk_n;
      end
   end

   // Next-state and next-output logic; every register holds unless a branch below updates it.
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      ready_n   = ready;
      busy_n    = busy;
      done_n    = 1'b0;
      sclk_n    = sclk;
      sdat_n    = sdat;
      rclk_n    = rclk;
      unique case (state)
         IDLE: begin
            if (load) begin
               shreg_n   = din;
               bit_cnt_n = '0;
               sclk_n    = 1'b0;
`ifdef LSB_FIRST_EN
               sdat_n    = din[0];
`else
               sdat_n    = din[WIDTH-1];
`endif
               busy_n    = 1'b1;
               ready_n   = 1'b0;
               state_n   = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!sclk) begin
                  sclk_n = 1'b1;
               end else if (bit_cnt == LAST_BIT) begin
                  // Falling edge after the last bit: park the line and strobe the storage latch.
                  sclk_n  = 1'b0;
                  sdat_n  = 1'b0;
                  rclk_n  = 1'b1;
                  state_n = LATCH;
               end else begin
                  sclk_n    = 1'b0;
                  bit_cnt_n = bit_cnt + BW'(1);
`ifdef LSB_FIRST_EN
                  shreg_n   = shreg >> 1;
                  sdat_n    = shreg[1];
`else
                  shreg_n   = shreg << 1;
                  sdat_n    = shreg[WIDTH-2];
`endif
               end
            end
         end
         LATCH: begin
            if (tick) begin
               rclk_n  = 1'b0;
               busy_n  = 1'b0;
               ready_n = 1'b1;
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            ready_n = 1'b1;
            sclk_n  = 1'b0;
            sdat_n  = 1'b0;
            rclk_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_latch_shift_out.sv
// Directed bench for latch_shift_out: WIDTH=8 with CLK_DIV=2 (dut) and CLK_DIV=1 (dut1).
module tb_latch_shift_out;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0;
   logic [7:0] din = 8'h00;
   logic       ready, busy, done, sclk, sdat, rclk;
   logic       load1 = 1'b0;
   logic [7:0] din1 = 8'h00;
   logic       ready1, busy1, done1, sclk1, sdat1, rclk1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   latch_shift_out #(.WIDTH(8), .CLK_DIV(2)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .din(din),
      .ready(ready), .busy(busy), .done(done), .sclk(sclk), .sdat(sdat), .rclk(rclk)
   );

   latch_shift_out #(.WIDTH(8), .CLK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .load(load1), .din(din1),
      .ready(ready1), .busy(busy1), .done(done1), .sclk(sclk1), .sdat(sdat1), .rclk(rclk1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One transfer on dut; returns at the negedge of the done cycle.
   task automatic send(input logic [7:0] d, input bit chained, input bit keep, input bit tgl);
      int nbusy = 0, nrise = 0, nrclk = 0, nviol = 0;
      logic [7:0] rx = 8'h00;
      logic ps = 1'b0, pd = 1'b0;
      if (!chained) @(negedge clk);
      chk("ready_before", 32'(ready), 32'd1);
      load = 1'b1;
      din  = d;
      @(negedge clk);
      if (!keep) load = 1'b0;
      while (busy && nbusy < 200) begin
         nbusy++;
         if (ready !== ~busy) nviol++;
         if (rclk && sclk) nviol++;
         if (sclk && (sdat !== pd)) nviol++;
         if (sclk && !ps) begin
            nrise++;
`ifdef LSB_FIRST_EN
            rx = {sdat, rx[7:1]};
`else
            rx = {rx[6:0], sdat};
`endif
         end
         if (rclk) nrclk++;
         ps = sclk;
         pd = sdat;
         if (tgl) begin
            din  = ~din;
            load = ~load;
         end
         @(negedge clk);
      end
      chk("busy_cycles", 32'(nbusy), 32'd34);
      chk("done_pulse", 32'(done), 32'd1);
      chk("ready_done", 32'(ready), 32'd1);
      chk("serial_word", 32'(rx), 32'(d));
      chk("sclk_rises", 32'(nrise), 32'd8);
      chk("rclk_cycles", 32'(nrclk), 32'd2);
      chk("invariants", 32'(nviol), 32'd0);
      if (!keep) load = 1'b0;
   endtask

   initial begin
      int nrise, nbusy, ntog, nones;
      logic ps;

      // Reset state
      #12;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_sdat", 32'(sdat), 32'd0);
      chk("rst_rclk", 32'(rclk), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single transfer of A5
      send(8'hA5, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_after", 32'(busy), 32'd0);

      // Back-to-back with load held high; din switched in the done cycle
      send(8'h01, 1'b0, 1'b1, 1'b0);
      send(8'h80, 1'b1, 1'b1, 1'b0);
      load = 1'b0;
      @(negedge clk);
      chk("no_extra_xfer", 32'(busy), 32'd0);
      chk("no_extra_done", 32'(done), 32'd0);

      // din and load toggling during the transfer are ignored
      send(8'hC3, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("tgl_no_extra", 32'(busy), 32'd0);

      // Reset in the middle of a transfer of FF
      load = 1'b1;
      din  = 8'hFF;
      @(negedge clk);
      load  = 1'b0;
      nrise = 0;
      ps    = 1'b0;
      for (int i = 0; i < 100 && nrise < 4; i++) begin
         if (sclk && !ps) nrise++;
         ps = sclk;
         if (nrise < 4) @(negedge clk);
      end
      chk("mid_rises", 32'(nrise), 32'd4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_sclk", 32'(sclk), 32'd0);
      chk("mid_rst_sdat", 32'(sdat), 32'd0);
      chk("mid_rst_rclk", 32'(rclk), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      ntog = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rclk || busy) ntog++;
      end
      chk("mid_rst_hold", 32'(ntog), 32'd0);
      rst_n = 1'b1;
      send(8'h3C, 1'b0, 1'b0, 1'b0);

      // CLK_DIV=1 instance, all-zero word
      @(negedge clk);
      load1 = 1'b1;
      din1  = 8'h00;
      @(negedge clk);
      load1 = 1'b0;
      nbusy = 0;
      nrise = 0;
      ntog  = 0;
      nones = 0;
      ps    = 1'b0;
      while (busy1 && nbusy < 100) begin
         nbusy++;
         if (sclk1 && !ps) nrise++;
         if (sclk1 !== ps) ntog++;
         if (sdat1) nones++;
         ps = sclk1;
         @(negedge clk);
      end
      chk("div1_busy", 32'(nbusy), 32'd17);
      chk("div1_rises", 32'(nrise), 32'd8);
      chk("div1_toggles", 32'(ntog), 32'd16);
      chk("div1_sdat_zero", 32'(nones), 32'd0);
      chk("div1_done", 32'(done1), 32'd1);
      @(negedge clk);
      chk("div1_done_end", 32'(done1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
